sprite_tile_fetcher: RTL

//  Parametrised sprite-tile fetch engine for the GPU line-buffer path. On a start pulse it latches
//  one sprite's attributes, then walks every tile column of the sprite row. Per column it reads one

---
 rtl/sprite_tile_fetcher.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sprite_tile_fetcher.sv
// Sprite tile-row fetch engine: reads one pixel row per tile column of a sprite from VRAM,
// applies horizontal/vertical flip and streams the rows to the line buffer.
module sprite_tile_fetcher #(
  parameter int BPP    = 4,
  parameter int TILE_W = 8,
  parameter int TILE_H = 8,
  parameter int TX_W   = 4,
  parameter int TY_W   = 4,
  parameter int TBL_W  = 1,
  localparam int DATA_W = BPP * TILE_W,
  localparam int ROW_W  = $clog2(TILE_H),
  localparam int ADDR_W = TBL_W + TY_W + TX_W + ROW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              hflip,
  input  logic              vflip,
  input  logic [TX_W-1:0]   size_x,
  input  logic [TBL_W-1:0]  tile_table,
  input  logic [TX_W-1:0]   tile_x,
  input  logic [TY_W-1:0]   tile_y_total,
  input  logic [ROW_W-1:0]  tile_y_offset,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TX_W-1:0]   out_tile,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, HOLD = 2'd2} state_t;

  state_t             state, state_next;
  logic               hflip_q, vflip_q;
  logic [TX_W-1:0]    size_q, tx_q, n;
  logic [TBL_W-1:0]   tbl_q;
  logic [TY_W-1:0]    ty_q;
  logic [ROW_W-1:0]   yoff_q;
  logic               fresh;
  logic [DATA_W-1:0]  data_q, rd_flip;
  logic               is_last, kill, accept;
  logic [TX_W-1:0]    offset, x_total;
  logic [ROW_W-1:0]   row;

  assign is_last = (n == size_q);
  assign kill    = abort && (state != IDLE);
  assign accept  = (state == HOLD) && out_ready && !abort;

  // Horizontal flip walks the columns right-to-left; the column index wraps inside the table.
  assign offset  = hflip_q ? size_q - n : n;
  assign x_total = tx_q + offset;
  assign row     = vflip_q ? ROW_W'(TILE_H - 1) - yoff_q : yoff_q;

  always_comb begin
    rd_flip = rd_data;
    if (hflip_q) begin
      for (int i = 0; i < TILE_W; i++) begin
        rd_flip[i*BPP +: BPP] = rd_data[(TILE_W-1-i)*BPP +: BPP];
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    rd_en      = 1'b0;
    rd_addr    = '0;
    out_valid  = 1'b0;
    case (state)
      IDLE: if (start) state_next = READ;
      READ: begin
        rd_en      = 1'b1;
        rd_addr    = {tbl_q, ty_q, x_total, row};
        state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = is_last ? IDLE : READ;
      end
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  // VRAM data is only valid in the first HOLD cycle: forward it then, replay the copy after.
  assign out_data = fresh ? rd_flip : data_q;
  assign out_tile = out_valid ? n : '0;
  assign out_last = out_valid && is_last;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      hflip_q <= 1'b0;
      vflip_q <= 1'b0;
      size_q  <= '0;
      tx_q    <= '0;
      tbl_q   <= '0;
      ty_q    <= '0;
      yoff_q  <= '0;
      n       <= '0;
      fresh   <= 1'b0;
      data_q  <= '0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      state <= state_next;
      fresh <= (state == READ) && !abort;
      done  <= accept && is_last;
      if (fresh) data_q <= rd_flip;
      if (state == IDLE && start) begin
        hflip_q <= hflip;
        vflip_q <= vflip;
        size_q  <= size_x;
        tx_q    <= tile_x;
        tbl_q   <= tile_table;
        ty_q    <= tile_y_total;
        yoff_q  <= tile_y_offset;
        n       <= '0;
      end else if (accept && !is_last) begin
        n <= n + 1'b1;
      end
    end
  end

endmodule
